// File: rtl/regfile_sb.sv
// regfile_sb: parametrised, scoreboarded register file.
//   Storage is one regfile_sb_entry per register, holding its data and its
//   pending bit. Reads are combinational with a same-cycle write bypass.
//   Pending bits are set on issue and cleared by the matching write. They
//   flag read-after-write and write-after-write hazards against units
//   that write back several cycles after issue.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ra, rb / o_a, o_b     read ports (address in, data out), write-bypassed
//   we, wa, wd            write port; a write also clears the pending bit
//   iss_valid, iss_rd     issue; sets the pending bit of iss_rd
//   o_busy_a, o_busy_b    read register is pending (a same-cycle write un-busies it)
//   o_hazard              busy_a | busy_b | (iss_valid & pend[iss_rd])
//   o_pending, o_regs     stored pending bits and flat register export (no bypass)

module regfile_sb_entry #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             iss_i,
  output logic [WIDTH-1:0] val_o,
  output logic             pend_o
);
  logic [WIDTH-1:0] val_q, val_d;
  logic             pend_q, pend_d;

  always_comb begin
    val_d  = val_q;
    pend_d = pend_q;
    if (wr_i) begin
      val_d  = wd_i;
      pend_d = 1'b0;
    end
    // An issue in the same cycle belongs to a newer instruction, so it wins.
    if (iss_i) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      pend_q <= pend_d;
    end
  end

  assign val_o  = val_q;
  assign pend_o = pend_q;
endmodule

module regfile_sb #(
  parameter  int WIDTH   = 16,
  parameter  int DEPTH   = 4,
  parameter  int ZERO_R0 = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          ra,
  input  logic [AW-1:0]          rb,
  output logic [WIDTH-1:0]       o_a,
  output logic [WIDTH-1:0]       o_b,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  output logic                   o_busy_a,
  output logic                   o_busy_b,
  output logic                   o_hazard,
  output logic [DEPTH-1:0]       o_pending,
  output logic [DEPTH*WIDTH-1:0] o_regs
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            pend, wr_hit, iss_hit;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      // With ZERO_R0 the zero register is never written nor issued to, so
      // its storage stays at its reset value of 0 and it never goes pending.
      localparam bit LIVE = !((ZERO_R0 != 0) && (i == 0));

      assign wr_hit[i]  = LIVE && we        && (wa     == AW'(i));
      assign iss_hit[i] = LIVE && iss_valid && (iss_rd == AW'(i));

      regfile_sb_entry #(.WIDTH(WIDTH)) u_ent (
        .clk    (clk),
        .rst    (rst),
        .wr_i   (wr_hit[i]),
        .wd_i   (wd),
        .iss_i  (iss_hit[i]),
        .val_o  (regs[i]),
        .pend_o (pend[i])
      );

      assign o_regs[i*WIDTH +: WIDTH] = regs[i];
    end
  endgenerate

  logic hit_a, hit_b, zero_a, zero_b;

  always_comb begin
    hit_a  = we && (wa == ra);
    hit_b  = we && (wa == rb);
    zero_a = (ZERO_R0 != 0) && (ra == '0);
    zero_b = (ZERO_R0 != 0) && (rb == '0);

    o_a = zero_a ? '0 : (hit_a ? wd : regs[ra]);
    o_b = zero_b ? '0 : (hit_b ? wd : regs[rb]);

    // A result landing this cycle un-busies the read. The zero register
    // never pends, so its address needs no special case here.
    o_busy_a = pend[ra] & ~hit_a;
    o_busy_b = pend[rb] & ~hit_b;
    // Recomputed from state and inputs rather than from o_busy_*.
    o_hazard = (pend[ra] & ~hit_a) | (pend[rb] & ~hit_b) | (iss_valid & pend[iss_rd]);
  end

  assign o_pending = pend;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded register file: the next generation of the VDP's fixed 4 x 16-bit register file. It adds configurable width and depth, two independent read ports with same-cycle write bypass, a synchronous clear, an optional hard-wired zero register, and a per-register pending bit. The pending bit lets the VDP control sequencer detect read-after-write and write-after-write hazards against multi-cycle units (blitter, line engine) whose results write back several cycles after issue.

## Interface

Parameters:
- WIDTH, 16: data width of every register.
- DEPTH, 4: number of registers; power of two, at least 2.
- ZERO_R0, 0: if 1, register 0 always reads 0, ignores writes and is never pending.
- AW, log2(DEPTH): address width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ra  in  AW  read port A address.
- rb  in  AW  read port B address.
- o_a  out  WIDTH  read port A data.
- o_b  out  WIDTH  read port B data.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- iss_valid  in  1  an instruction targeting iss_rd is issued this cycle.
- iss_rd  in  AW  destination register of the issued instruction.
- o_busy_a  out  1  register ra is pending.
- o_busy_b  out  1  register rb is pending.
- o_hazard  out  1  o_busy_a OR o_busy_b OR (iss_valid AND register iss_rd is pending).
- o_pending  out  DEPTH  pending bit vector; bit i is register i.
- o_regs  out  DEPTH*WIDTH  flat debug export; register i occupies bits [i*WIDTH +: WIDTH].

## Operation

State:
- reg[0..DEPTH-1], each WIDTH bits.
- pend[0..DEPTH-1], each 1 bit.

Reset:
- rst=1 at a rising edge clears every reg and every pend bit to 0.
- Reset overrides we and iss_valid in the same cycle.
- The outputs after the reset edge are: o_a=o_b=0, o_regs=0, o_pending=0, o_busy_*=0, o_hazard=0 (o_hazard=0 requires iss_valid=0).
- A reset asserted while writes are outstanding discards them. The owning units are reset by the same rst.

Write:
- we=1 at an edge loads reg[wa] <= wd and clears pend[wa].
- If ZERO_R0=1 and wa=0, the write is ignored entirely.

Issue:
- iss_valid=1 at an edge sets pend[iss_rd].
- If ZERO_R0=1 and iss_rd=0, the issue is ignored.
- Simultaneous write and issue to the same register: data is written and pend stays 1. The issue wins because it belongs to a newer instruction.
- Issuing to an already-pending register is a protocol violation. Upstream must hold iss_valid low while o_hazard=1. If it happens anyway, pend stays 1 with no other effect.

Read (combinational):
- o_a = wd if we=1 and wa=ra (bypass); otherwise o_a = reg[ra].
- o_b follows the same rule with rb.
- With ZERO_R0=1, address 0 reads 0 and the bypass does not apply.
- o_busy_a = pend[ra] AND NOT (we AND wa=ra). A result arriving in the same cycle un-busies the read. o_busy_b follows the same rule with rb.
- o_pending and o_regs reflect stored state only, with no bypass.
- Both read ports may address the same register and the write address simultaneously; each returns the bypassed value.

Widths:
- Addresses are full range; there is no out-of-range case because DEPTH = 2^AW.
- Data is stored unmodified, with no sign or width conversion.

## Timing

- Read latency is 0 cycles (combinational from ra/rb, we, wa, wd).
- Write-to-storage latency is 1 cycle. o_regs and o_pending update the cycle after the edge.
- Write-to-read latency is 0 cycles through the bypass, with the value valid in the same cycle as we.
- Issue-to-busy latency is 1 cycle. The issuing cycle itself does not see its own pend bit, except through the iss_rd term of o_hazard for a register that was already pending.
- Pend is cleared only by a write or by reset; there is no timeout.
- Every output has a single combinational path from inputs or state; no output depends on another output.

## Test plan

- Reset: load all regs with 16'hFFFF and issue to every register, then pulse rst for 1 cycle -> o_regs=0, o_pending=0, o_a=o_b=0 on the following cycle.
- Bypass: we=1, wa=2, wd=16'h1234, ra=rb=2 in the same cycle -> o_a=o_b=16'h1234 that cycle, and reg[2]=16'h1234 stored on the next cycle.
- Scoreboard: iss_valid=1 with iss_rd=3, then ra=3 -> o_busy_a=1 and o_hazard=1 until the cycle where we=1, wa=3. In that cycle o_busy_a=0, and o_pending[3]=0 on the next cycle.
- Write and issue collide: we=1, wa=1, wd=16'hA5A5 with iss_valid=1, iss_rd=1 in the same cycle -> reg[1]=16'hA5A5 and o_pending[1]=1 on the next cycle.
- ZERO_R0=1, DEPTH=8, WIDTH=32: we=1, wa=0, wd=32'hDEADBEEF together with iss_valid=1, iss_rd=0 -> o_a=0 for ra=0, and o_pending[0]=0 at all times.
- Randomised write/issue/read traffic against a reference model for 10k cycles, with rst pulsed mid-run -> no mismatch on o_a, o_b, o_busy_a, o_busy_b, o_hazard, o_pending or o_regs.
